ps2_char_transmitter: RTL and testbench

- Device-side PS/2 keyboard emulator that runs the keyboard decode path in the other direction.
- Accepts a sprite character code over a valid/ready handshake and looks up its PS/2 set-2 scan code.
- Serialises the scan code as PS/2 frames: the make code, then the F0 + code break sequence.
- Drives the on-board keyboard receiver path in loopback and simulation, and lets firmware inject keystrokes without a physical keyboard.

---
 rtl/ps2_char_transmitter.sv | 171 +++++++++++++++++
 tb/tb_ps2_char_transmitter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_char_transmitter.sv
// Device-side PS/2 keyboard emulator: turns a sprite character code into
// set-2 make (and optionally F0 + break) frames on open-collector style lines.
module ps2_char_transmitter #(
  parameter int HALF_PERIOD = 4000,
  parameter int GAP_CYCLES  = 8000,
  parameter bit SEND_BREAK  = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] char_in,
  input  logic        char_valid_in,
  output logic        char_ready_out,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic        busy_out,
  output logic        unmapped_out
);

  localparam int BIT_CYC = 2 * HALF_PERIOD;
  localparam int HP_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [HP_W-1:0]  HP_LAST   = HP_W'(BIT_CYC - 1);
  localparam logic [HP_W-1:0]  HP_FALL   = HP_W'(HALF_PERIOD);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST  = 4'd10;
  localparam logic [1:0]       LAST_BYTE = SEND_BREAK ? 2'd2 : 2'd0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_BIT   = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // {mapped, scan code}; zero when the character has no key.
  function automatic logic [8:0] scan_lookup(input logic [15:0] c);
    logic [8:0] r;
    r = 9'h000;
    case (c)
      16'd0:  r = 9'h129;  16'd1:  r = 9'h11C;  16'd2:  r = 9'h132;
      16'd3:  r = 9'h121;  16'd4:  r = 9'h123;  16'd5:  r = 9'h124;
      16'd6:  r = 9'h12B;  16'd7:  r = 9'h134;  16'd8:  r = 9'h133;
      16'd9:  r = 9'h143;  16'd10: r = 9'h13B;  16'd11: r = 9'h142;
      16'd12: r = 9'h14B;  16'd13: r = 9'h13A;  16'd14: r = 9'h131;
      16'd15: r = 9'h144;  16'd16: r = 9'h14D;  16'd17: r = 9'h115;
      16'd18: r = 9'h12D;  16'd19: r = 9'h11B;  16'd20: r = 9'h12C;
      16'd21: r = 9'h13C;  16'd22: r = 9'h12A;  16'd23: r = 9'h11D;
      16'd24: r = 9'h122;  16'd25: r = 9'h135;  16'd26: r = 9'h11A;
      16'd27: r = 9'h166;  16'd32: r = 9'h141;  16'd33: r = 9'h149;
      16'd35: r = 9'h116;  16'd36: r = 9'h11E;  16'd37: r = 9'h126;
      16'd38: r = 9'h125;  16'd39: r = 9'h12E;  16'd40: r = 9'h136;
      16'd41: r = 9'h13D;  16'd42: r = 9'h13E;  16'd43: r = 9'h146;
      16'd44: r = 9'h145;  16'd48: r = 9'h15A;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] byte_value(input logic [1:0] idx, input logic [7:0] scan);
    return (idx == 2'd1) ? 8'hF0 : scan;
  endfunction

  // Frame bit order on the wire: start, data LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    return f[idx];
  endfunction

  logic [1:0]       state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [3:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             clk_q, clk_d;
  logic             data_q, data_d;
  logic [15:0]      char_q;
  logic [8:0]       lookup;
  logic             mapped;
  logic             xfer;

  assign lookup = scan_lookup(char_q);
  assign mapped = lookup[8];

  assign char_ready_out = (state_q == S_IDLE) && !rst_in;
  assign xfer           = char_valid_in && char_ready_out;
  assign busy_out       = ((state_q == S_CHECK) && mapped) || (state_q == S_BIT) || (state_q == S_GAP);
  assign unmapped_out   = (state_q == S_CHECK) && !mapped;
  assign ps2_clk_out    = clk_q;
  assign ps2_data_out   = data_q;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mapped) begin
          state_d = S_BIT;
          byte_d  = 2'd0;
          bit_d   = 4'd0;
          hp_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BIT: begin
        if (hp_q == HP_LAST) begin
          hp_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = 4'd0;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (byte_q == LAST_BYTE) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 4'd0;
            hp_d    = '0;
            state_d = S_BIT;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Lines are registered from the next state so they change cleanly with it.
    clk_d  = !((state_d == S_BIT) && (hp_d >= HP_FALL));
    data_d = (state_d == S_BIT) ? frame_bit(byte_value(byte_d, lookup[7:0]), bit_d) : 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      hp_q    <= '0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      gap_q   <= '0;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (xfer) char_q <= char_in;
  end

endmodule

// File: tb/tb_ps2_char_transmitter.sv
// Bench for ps2_char_transmitter: a PS/2 line receiver decodes frames and
// compares them against a scan-table model of the character-to-keystroke rules.
module tb_ps2_char_transmitter;

  localparam int HP   = 4;
  localparam int GAP  = 8;
  localparam int BYTE_CYC = 22 * HP + GAP;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] chr_a = 16'd0, chr_b = 16'd0;
  logic        vld_a = 1'b0, vld_b = 1'b0;
  logic        rdy_a, pclk_a, pdat_a, busy_a, unm_a;
  logic        rdy_b, pclk_b, pdat_b, busy_b, unm_b;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  ps2_char_transmitter #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .SEND_BREAK(1'b1)) dut_a (
    .clk_in(clk_in), .rst_in(rst), .char_in(chr_a), .char_valid_in(vld_a),
    .char_ready_out(rdy_a), .ps2_clk_out(pclk_a), .ps2_data_out(pdat_a),
    .busy_out(busy_a), .unmapped_out(unm_a));

  ps2_char_transmitter #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .SEND_BREAK(1'b0)) dut_b (
    .clk_in(clk_in), .rst_in(rst), .char_in(chr_b), .char_valid_in(vld_b),
    .char_ready_out(rdy_b), .ps2_clk_out(pclk_b), .ps2_data_out(pdat_b),
    .busy_out(busy_b), .unmapped_out(unm_b));

  // Line receivers: sample data on each falling PS/2 clock, 11 bits per frame.
  logic        prev_a = 1'b1, prev_b = 1'b1;
  int          nb_a = 0, nb_b = 0, fcnt_a = 0, fcnt_b = 0, edges_a = 0, edges_b = 0;
  logic [10:0] sh_a = '0, sh_b = '0;
  logic [10:0] frm_a [0:63];
  logic [10:0] frm_b [0:63];

  always @(posedge clk_in) begin
    prev_a <= pclk_a;
    if (prev_a === 1'b1 && pclk_a === 1'b0) edges_a <= edges_a + 1;
    if (rst) nb_a <= 0;
    else if (prev_a === 1'b1 && pclk_a === 1'b0) begin
      if (nb_a == 10) begin
        frm_a[fcnt_a % 64] <= {pdat_a, sh_a[9:0]};
        fcnt_a <= fcnt_a + 1;
        nb_a   <= 0;
      end else begin
        sh_a[nb_a] <= pdat_a;
        nb_a <= nb_a + 1;
      end
    end
  end

  always @(posedge clk_in) begin
    prev_b <= pclk_b;
    if (prev_b === 1'b1 && pclk_b === 1'b0) edges_b <= edges_b + 1;
    if (rst) nb_b <= 0;
    else if (prev_b === 1'b1 && pclk_b === 1'b0) begin
      if (nb_b == 10) begin
        frm_b[fcnt_b % 64] <= {pdat_b, sh_b[9:0]};
        fcnt_b <= fcnt_b + 1;
        nb_b   <= 0;
      end else begin
        sh_b[nb_b] <= pdat_b;
        nb_b <= nb_b + 1;
      end
    end
  end

  int scan_tbl [int];
  int pairs [82] = '{
     0,'h29,  1,'h1C,  2,'h32,  3,'h21,  4,'h23,  5,'h24,  6,'h2B,  7,'h34,
     8,'h33,  9,'h43, 10,'h3B, 11,'h42, 12,'h4B, 13,'h3A, 14,'h31, 15,'h44,
    16,'h4D, 17,'h15, 18,'h2D, 19,'h1B, 20,'h2C, 21,'h3C, 22,'h2A, 23,'h1D,
    24,'h22, 25,'h35, 26,'h1A, 27,'h66, 32,'h41, 33,'h49, 35,'h16, 36,'h1E,
    37,'h26, 38,'h25, 39,'h2E, 40,'h36, 41,'h3D, 42,'h3E, 43,'h46, 44,'h45,
    48,'h5A};

  function automatic int ref_code(input int c);
    return scan_tbl.exists(c) ? scan_tbl[c] : -1;
  endfunction

  // Expected wire frame for a byte, from the framing rules.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Leaves the caller in the cycle right after the transfer.
  task automatic xfer_a(input int c, input string tag);
    int n;
    n = 0;
    while (rdy_a !== 1'b1 && n < 1000) begin tick(); n++; end
    chk({tag, "_ready_wait"}, 32'(rdy_a), 32'd1);
    chr_a = 16'(c);
    vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    chr_a = 16'hFFFF;
  endtask

  task automatic run_a(input int c, input string tag, output int base);
    int code, n, e0;
    code = ref_code(c);
    base = fcnt_a;
    e0   = edges_a;
    xfer_a(c, tag);
    chk({tag, "_ready_drop"}, 32'(rdy_a), 32'd0);
    chk({tag, "_unmapped"}, 32'(unm_a), 32'(code < 0));
    n = 0;
    while (busy_a === 1'b1 && n < 1000) begin tick(); n++; end
    chk({tag, "_busy_len"}, 32'(n), (code < 0) ? 32'd0 : 32'(1 + 3 * BYTE_CYC));
    if (code < 0) begin
      chk({tag, "_lines"}, 32'({pclk_a, pdat_a}), 32'd3);
      tick();
      chk({tag, "_unm_pulse_end"}, 32'(unm_a), 32'd0);
      chk({tag, "_edges"}, 32'(edges_a - e0), 32'd0);
    end
    chk({tag, "_ready_back"}, 32'(rdy_a), 32'd1);
    chk({tag, "_nframes"}, 32'(fcnt_a - base), (code < 0) ? 32'd0 : 32'd3);
    for (int i = 0; i < 3 && i < fcnt_a - base; i++)
      chk({tag, "_frame"}, 32'(frm_a[(base + i) % 64]),
          32'(ref_frame((i == 1) ? 8'hF0 : 8'(code))));
  endtask

  initial begin
    int base, n, e0, f0, code, c;
    logic lines_ok;
    logic [10:0] exp1c;
    int bits1c [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 82; i += 2) scan_tbl[pairs[i]] = pairs[i + 1];

    // Reset then idle
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_lines_a", 32'({pclk_a, pdat_a}), 32'd3);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_ready_a", 32'(rdy_a), 32'd0);
      chk("rst_unm_a", 32'(unm_a), 32'd0);
      chk("rst_lines_b", 32'({pclk_b, pdat_b, busy_b, rdy_b}), 32'b1100);
    end
    rst = 1'b0;
    tick();
    chk("ready_after_rst_a", 32'(rdy_a), 32'd1);
    chk("ready_after_rst_b", 32'(rdy_b), 32'd1);
    lines_ok = 1'b1;
    repeat (20) begin
      tick();
      if ({pclk_a, pdat_a, pclk_b, pdat_b} !== 4'hF) lines_ok = 1'b0;
    end
    chk("idle_lines", 32'(lines_ok), 32'd1);

    // Char 1: explicit bit pattern of 1C and parity of F0
    run_a(1, "char1", base);
    for (int i = 0; i < 11; i++) exp1c[i] = bits1c[i][0];
    chk("char1_1C_bits", 32'(frm_a[base % 64]), 32'(exp1c));
    chk("char1_F0_parity", 32'(frm_a[(base + 1) % 64][9]), 32'd1);

    // Char 48 with break
    run_a(48, "enter", base);
    for (int i = 0; i < 3; i++) chk("enter_parity", 32'(frm_a[(base + i) % 64][9]), 32'd1);

    // Char 48 make only
    base = fcnt_b;
    n = 0;
    while (rdy_b !== 1'b1 && n < 1000) begin tick(); n++; end
    chr_b = 16'd48;
    vld_b = 1'b1;
    tick();
    vld_b = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 1000) begin tick(); n++; end
    chk("enter_nb_busy_len", 32'(n), 32'(1 + BYTE_CYC));
    chk("enter_nb_ready", 32'(rdy_b), 32'd1);
    chk("enter_nb_nframes", 32'(fcnt_b - base), 32'd1);
    chk("enter_nb_frame", 32'(frm_b[base % 64]), 32'(ref_frame(8'h5A)));

    // Unmapped char
    run_a(30, "unmapped30", base);

    // Randomised characters, including far out-of-table codes
    for (int k = 0; k < 8; k++) begin
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 50));
      run_a(c, $sformatf("rand%0d_c%0d", k, c), base);
    end

    // Back-to-back with valid held high throughout
    base = fcnt_a;
    xfer_a(0, "b2b_first");
    chr_a = 16'd27;
    vld_a = 1'b1;
    n = 1;
    while (rdy_a !== 1'b1 && n < 1000) begin tick(); n++; end
    chk("b2b_second_accept_cycle", 32'(n), 32'(2 + 3 * BYTE_CYC));
    chk("b2b_busy_at_accept", 32'(busy_a), 32'd0);
    tick();
    vld_a = 1'b0;
    chk("b2b_ready_drop", 32'(rdy_a), 32'd0);
    n = 0;
    while (busy_a === 1'b1 && n < 1000) begin tick(); n++; end
    chk("b2b_busy_len2", 32'(n), 32'(1 + 3 * BYTE_CYC));
    chk("b2b_nframes", 32'(fcnt_a - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      code = (i < 3) ? ref_code(0) : ref_code(27);
      chk($sformatf("b2b_frame%0d", i), 32'(frm_a[(base + i) % 64]),
          32'(ref_frame((i % 3 == 1) ? 8'hF0 : 8'(code))));
    end

    // Reset during data bit 3 of the F0 byte
    base = fcnt_a;
    xfer_a(1, "midrst");
    n = 0;
    while (!(fcnt_a == base + 1 && nb_a == 5) && n < 1000) begin tick(); n++; end
    chk("midrst_reached_bit3", 32'(n < 1000), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_lines", 32'({pclk_a, pdat_a}), 32'd3);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_ready_in_rst", 32'(rdy_a), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_ready_after", 32'(rdy_a), 32'd1);
    e0 = edges_a;
    f0 = fcnt_a;
    lines_ok = 1'b1;
    repeat (150) begin
      tick();
      if ({pclk_a, pdat_a, busy_a} !== 3'b110) lines_ok = 1'b0;
    end
    chk("midrst_quiet", 32'(lines_ok), 32'd1);
    chk("midrst_no_edges", 32'(edges_a - e0), 32'd0);
    chk("midrst_no_frames", 32'(fcnt_a - f0), 32'd0);

    // Recovery: a normal character still works after the abort
    run_a(27, "post_rst", base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
